// File: rtl/rr_arbiter_n_pkg.sv
// Shared helpers for the round-robin arbiter slice.
// Width helper used to size index and hold-counter fields.
package rr_arbiter_n_pkg;

  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter_n_pick.sv
// Combinational round-robin search: first set request after base, wrapping.
// Upper copy of the request vector covers the wrap-around half.
module rr_pick
  import rr_arbiter_n_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0]   i_request,
  input  logic [W-1:0]   i_base,
  output logic           o_found,
  output logic [W-1:0]   o_index
);

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i > int'(i_base));
    end
    w_dbl   = {i_request, i_request & w_mask};
    o_found = |i_request;
    o_index = '0;
    // Scan downward so the lowest set position wins.
    for (int j = 2 * N - 1; j >= 0; j--) begin
      if (w_dbl[j]) begin
        o_index = (j >= N) ? W'(j - N) : W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way round-robin arbiter with registered one-hot grant,
// zero-bubble handoff and optional hold-quantum preemption.
module rr_arbiter_n
  import rr_arbiter_n_pkg::*;
#(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8,
  localparam int W       = clog2_min1(N),
  localparam int CW      = clog2_min1(HOLD_MAX + 1)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [N-1:0] request,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [W-1:0] grant_index
);

  logic [N-1:0]  r_grant;
  logic          r_valid;
  logic [W-1:0]  r_index;
  logic [W-1:0]  r_last;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_base;
  logic          w_found;
  logic [W-1:0]  w_pick;
  logic          w_own_req;
  logic          w_others;
  logic          w_sat;
  logic          w_idle;
  logic          w_rel;
  logic          w_pre;
  logic          w_keep;
  logic          w_take;
  logic          w_nvalid;
  logic [W-1:0]  w_nindex;
  logic [CW-1:0] w_ncnt;
  logic [N-1:0]  w_ngrant;

  assign w_base    = r_valid ? r_index : r_last;
  assign w_own_req = |(request & r_grant);
  assign w_others  = |(request & ~r_grant);
  assign w_sat     = (r_cnt == CW'(HOLD_MAX));

  assign w_idle = !r_valid;
  assign w_rel  = r_valid && !w_own_req;
  assign w_pre  = r_valid && w_own_req &&
                  (HOLD_MAX != 0) && w_sat && w_others;
  assign w_keep = r_valid && w_own_req && !w_pre;

  rr_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .i_request (request),
    .i_base    (w_base),
    .o_found   (w_found),
    .o_index   (w_pick)
  );

  always_comb begin
    w_take   = 1'b0;
    w_nvalid = r_valid;
    w_nindex = r_index;
    w_ncnt   = r_cnt;
    unique case (1'b1)
      w_idle: w_take = w_found;
      w_rel: begin
        w_take = w_found;
        if (!w_found) begin
          w_nvalid = 1'b0;
          w_nindex = '0;
          w_ncnt   = '0;
        end
      end
      w_pre:  w_take = 1'b1;
      w_keep: w_ncnt = w_sat ? r_cnt : r_cnt + CW'(1);
      default: w_take = 1'b0;
    endcase
    if (w_take) begin
      w_nvalid = 1'b1;
      w_nindex = w_pick;
      w_ncnt   = CW'(1);
    end
    // Unlimited hold: counter is never consulted.
    if (HOLD_MAX == 0) w_ncnt = '0;
  end

  always_comb begin
    w_ngrant = '0;
    for (int i = 0; i < N; i++) begin
      w_ngrant[i] = w_nvalid && (w_nindex == W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant <= '0;
      r_valid <= 1'b0;
      r_index <= '0;
      r_last  <= W'(N - 1);
      r_cnt   <= '0;
    end else begin
      r_grant <= w_ngrant;
      r_valid <= w_nvalid;
      r_index <= w_nindex;
      r_cnt   <= w_ncnt;
      if (w_take) r_last <= w_pick;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_index = r_index;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench: N=4/HOLD_MAX=3 and N=5/HOLD_MAX=0 arbiters
// checked against a behavioural round-robin model.
module tb_rr_arbiter_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] req4;
  logic [3:0] g4;
  logic       gv4;
  logic [1:0] gi4;
  logic [4:0] req5;
  logic [4:0] g5;
  logic       gv5;
  logic [2:0] gi5;

  int total;
  int bad;

  int q4[$];
  int q5[$];

  int m_own[2];
  int m_last[2];
  int m_hold[2];
  int nn[2];
  int hh[2];

  rr_arbiter_n #(.N(4), .HOLD_MAX(3)) dut4 (
    .clock       (clk),
    .reset_n     (rst_n),
    .request     (req4),
    .grant       (g4),
    .grant_valid (gv4),
    .grant_index (gi4)
  );

  rr_arbiter_n #(.N(5), .HOLD_MAX(0)) dut5 (
    .clock       (clk),
    .reset_n     (rst_n),
    .request     (req5),
    .grant       (g5),
    .grant_valid (gv5),
    .grant_index (gi5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint a, input longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic int pick(input int n, input logic [7:0] r,
                              input int base);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (base + k) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    nn = '{4, 5};
    hh = '{3, 0};
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_last[d] = nn[d] - 1;
      m_hold[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [7:0] r);
    int p;
    int o;
    o = m_own[d];
    p = -1;
    if (o < 0) begin
      p = pick(nn[d], r, m_last[d]);
    end else if (!r[o]) begin
      p = pick(nn[d], r, o);
      if (p < 0) m_own[d] = -1;
    end else if (hh[d] != 0 && m_hold[d] == hh[d] &&
                 (r & ~(8'd1 << o)) != 8'd0) begin
      p = pick(nn[d], r, o);
    end else if (m_hold[d] < hh[d]) begin
      m_hold[d]++;
    end
    if (p >= 0) begin
      m_own[d]  = p;
      m_last[d] = p;
      m_hold[d] = 1;
    end
    if (d == 0) q4.push_back(m_own[0]);
    else q5.push_back(m_own[1]);
  endtask

  task automatic push_both();
    model_step(0, {4'd0, req4});
    model_step(1, {3'd0, req5});
  endtask

  task automatic step(input logic [3:0] r4, input logic [4:0] r5);
    @(negedge clk);
    req4 = r4;
    req5 = r5;
    push_both();
  endtask

  task automatic chk_own(input int d, input string nm, input int e);
    @(posedge clk);
    #2;
    if (d == 0) begin
      chk({nm, "_valid"}, gv4, (e >= 0) ? 1 : 0);
      chk({nm, "_index"}, gi4, (e >= 0) ? e : 0);
    end else begin
      chk({nm, "_valid"}, gv5, (e >= 0) ? 1 : 0);
      chk({nm, "_index"}, gi5, (e >= 0) ? e : 0);
    end
  endtask

  task automatic pulse_reset(input logic [3:0] r4, input logic [4:0] r5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_grant4", g4, 0);
    chk("async_rst_valid4", gv4, 0);
    chk("async_rst_grant5", g5, 0);
    model_reset();
    #1 rst_n = 1'b1;
    req4 = r4;
    req5 = r5;
    push_both();
  endtask

  // Monitor: pops the expected owner for every edge and checks invariants.
  initial begin
    logic [3:0] s4;
    logic [4:0] s5;
    int e;
    forever begin
      @(posedge clk);
      s4 = req4;
      s5 = req5;
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("sb4_grant", g4, (e >= 0) ? (1 << e) : 0);
        chk("sb4_index", gi4, (e >= 0) ? e : 0);
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        chk("sb5_grant", g5, (e >= 0) ? (1 << e) : 0);
        chk("sb5_index", gi5, (e >= 0) ? e : 0);
      end
      chk("inv4_onehot", $onehot0(g4), 1);
      chk("inv4_valid", gv4, |g4);
      chk("inv4_idx", g4[gi4], gv4);
      chk("inv4_req", g4 & ~s4, 0);
      chk("inv5_onehot", $onehot0(g5), 1);
      chk("inv5_valid", gv5, |g5);
      chk("inv5_idx", g5[gi5], gv5);
      chk("inv5_req", g5 & ~s5, 0);
    end
  end

  initial begin
    int t1[13];
    logic [3:0] r4;
    logic [4:0] r5;
    total = 0;
    bad   = 0;
    t1    = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    rst_n = 1'b0;
    req4  = '0;
    req5  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_grant4", g4, 0);
    chk("rst_valid4", gv4, 0);
    chk("rst_index4", gi4, 0);
    chk("rst_grant5", g5, 0);
    chk("rst_valid5", gv5, 0);
    chk("rst_index5", gi5, 0);

    @(negedge clk);
    rst_n = 1'b1;
    push_both();

    foreach (t1[i]) begin
      step(4'b1111, 5'b0);
      chk_own(0, "rotate", t1[i]);
    end

    repeat (10) begin
      step(4'b0100, 5'b0);
      chk_own(0, "lone_hold", 2);
    end
    step(4'b0101, 5'b0);
    chk_own(0, "preempt_sat", 0);

    step(4'b1010, 5'b0);
    chk_own(0, "own1", 1);
    step(4'b1000, 5'b0);
    chk_own(0, "handoff", 3);

    step(4'b0000, 5'b0);
    chk_own(0, "to_idle", -1);
    step(4'b0011, 5'b0);
    chk_own(0, "idle_wrap", 0);

    step(4'b0100, 5'b0);
    chk_own(0, "own2", 2);
    step(4'b0100, 5'b0);
    chk_own(0, "own2_mid", 2);
    pulse_reset(4'b1111, 5'b0);
    chk_own(0, "after_rst", 0);

    repeat (20) begin
      step(4'b0, 5'b11111);
      chk_own(1, "n5_nopre", 0);
    end
    step(4'b0, 5'b11110);
    chk_own(1, "n5_rel0", 1);
    step(4'b0, 5'b11100);
    chk_own(1, "n5_rel1", 2);
    step(4'b0, 5'b11000);
    chk_own(1, "n5_rel2", 3);
    step(4'b0, 5'b10000);
    chk_own(1, "n5_rel3", 4);
    step(4'b0, 5'b00011);
    chk_own(1, "n5_wrap", 0);

    r4 = '0;
    r5 = '0;
    repeat (600) begin
      if ($urandom_range(0, 3) == 0) r4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r5 = 5'($urandom_range(0, 31));
      step(r4, r5);
    end

    repeat (3) @(negedge clk);
    chk("drain4", q4.size(), 0);
    chk("drain5", q5.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
